// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: one request channel and its read response.
interface sram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one 1W/1R SRAM between requesters A and B with independent read/write
// round-robin arbitration, read-response routing and a saturating conflict counter.
module sram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    a_if,
    sram_port_arbiter_if.slave    b_if,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_ren,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [CNT_WIDTH-1:0]  o_conflict_cnt
);
    localparam logic                 PTR_A   = 1'b0;
    localparam logic                 PTR_B   = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 r_rd_last;
    logic                 r_wr_last;
    logic                 r_own_vld;
    logic                 r_own_id;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic w_a_rd, w_b_rd, w_a_wr, w_b_wr;
    logic w_rd_conf, w_wr_conf;
    logic w_rd_gnt_a, w_rd_gnt_b, w_wr_gnt_a, w_wr_gnt_b;
    logic w_a_rsp, w_b_rsp;

    // Per-port candidates and grants; nothing is granted while in reset.
    always_comb begin
        w_a_rd     = rst_n & a_if.req_valid & ~a_if.req_we;
        w_b_rd     = rst_n & b_if.req_valid & ~b_if.req_we;
        w_a_wr     = rst_n & a_if.req_valid &  a_if.req_we;
        w_b_wr     = rst_n & b_if.req_valid &  b_if.req_we;
        w_rd_conf  = w_a_rd & w_b_rd;
        w_wr_conf  = w_a_wr & w_b_wr;
        w_rd_gnt_a = w_a_rd & (~w_b_rd | (r_rd_last == PTR_B));
        w_rd_gnt_b = w_b_rd & ~w_rd_gnt_a;
        w_wr_gnt_a = w_a_wr & (~w_b_wr | (r_wr_last == PTR_B));
        w_wr_gnt_b = w_b_wr & ~w_wr_gnt_a;
    end

    // SRAM port muxing; idle ports drive zero address/data.
    always_comb begin
        o_mem_ren   = w_rd_gnt_a | w_rd_gnt_b;
        o_mem_raddr = '0;
        if (w_rd_gnt_a) begin
            o_mem_raddr = a_if.req_addr;
        end else if (w_rd_gnt_b) begin
            o_mem_raddr = b_if.req_addr;
        end
        o_mem_wen   = w_wr_gnt_a | w_wr_gnt_b;
        o_mem_waddr = '0;
        o_mem_wdata = '0;
        if (w_wr_gnt_a) begin
            o_mem_waddr = a_if.req_addr;
            o_mem_wdata = a_if.req_wdata;
        end else if (w_wr_gnt_b) begin
            o_mem_waddr = b_if.req_addr;
            o_mem_wdata = b_if.req_wdata;
        end
    end

    // Responses follow the registered read owner; reset suppresses an in-flight one.
    always_comb begin
        w_a_rsp = rst_n & r_own_vld & (r_own_id == PTR_A);
        w_b_rsp = rst_n & r_own_vld & (r_own_id == PTR_B);
    end

    assign a_if.req_ready = w_rd_gnt_a | w_wr_gnt_a;
    assign b_if.req_ready = w_rd_gnt_b | w_wr_gnt_b;
    assign a_if.rsp_valid = w_a_rsp;
    assign b_if.rsp_valid = w_b_rsp;
    assign a_if.rsp_rdata = w_a_rsp ? i_mem_rdata : '0;
    assign b_if.rsp_rdata = w_b_rsp ? i_mem_rdata : '0;
    assign o_conflict_cnt = r_cnt;

    // A and B can contend on at most one port per cycle, so the counter steps by one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_last <= PTR_B;
            r_wr_last <= PTR_B;
            r_own_vld <= 1'b0;
            r_own_id  <= PTR_A;
            r_cnt     <= '0;
        end else begin
            if (w_rd_conf) begin
                r_rd_last <= w_rd_gnt_a ? PTR_A : PTR_B;
            end
            if (w_wr_conf) begin
                r_wr_last <= w_wr_gnt_a ? PTR_A : PTR_B;
            end
            if ((w_rd_conf | w_wr_conf) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            r_own_vld <= o_mem_ren;
            r_own_id  <= w_rd_gnt_b;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: an SRAM stand-in, a rule-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_sram_port_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] conflict_cnt;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_if           (a_if),
        .b_if           (b_if),
        .o_mem_wen      (mem_wen),
        .o_mem_waddr    (mem_waddr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_ren      (mem_ren),
        .o_mem_raddr    (mem_raddr),
        .i_mem_rdata    (mem_rdata),
        .o_conflict_cnt (conflict_cnt)
    );

    // SRAM stand-in: 16 words, registered read with write-to-read forwarding.
    logic [DW-1:0] sram [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wen) sram[mem_waddr[3:0]] <= mem_wdata;
            if (mem_ren) mem_rdata <= (mem_wen && mem_waddr == mem_raddr) ? mem_wdata : sram[mem_raddr[3:0]];
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model state: last winner per port (0=A, 1=B), pending response, memory.
    int            m_last_rd = 1;
    int            m_last_wr = 1;
    int            m_cnt = 0;
    bit            m_own_v = 1'b0;
    int            m_own = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_mem [16];
    initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

    int            rd_win, wr_win, n_rd, n_wr;
    bit            ar, br, aw, bw;
    logic [AW-1:0] e_raddr, e_waddr;
    logic [DW-1:0] e_wdata, e_ra, e_rb;

    always @(negedge clk) begin
        ar = a_if.req_valid && !a_if.req_we;
        br = b_if.req_valid && !b_if.req_we;
        aw = a_if.req_valid &&  a_if.req_we;
        bw = b_if.req_valid &&  b_if.req_we;
        n_rd = int'(ar) + int'(br);
        n_wr = int'(aw) + int'(bw);
        rd_win = -1;
        wr_win = -1;
        if (rst_n) begin
            if (n_rd == 2) rd_win = 1 - m_last_rd;
            else if (ar) rd_win = 0;
            else if (br) rd_win = 1;
            if (n_wr == 2) wr_win = 1 - m_last_wr;
            else if (aw) wr_win = 0;
            else if (bw) wr_win = 1;
        end
        e_raddr = (rd_win == 0) ? a_if.req_addr : (rd_win == 1) ? b_if.req_addr : '0;
        e_waddr = (wr_win == 0) ? a_if.req_addr : (wr_win == 1) ? b_if.req_addr : '0;
        e_wdata = (wr_win == 0) ? a_if.req_wdata : (wr_win == 1) ? b_if.req_wdata : '0;
        e_ra = (rst_n && m_own_v && m_own == 0) ? m_data : '0;
        e_rb = (rst_n && m_own_v && m_own == 1) ? m_data : '0;

        chk("a_ready", 64'(a_if.req_ready), 64'(rd_win == 0 || wr_win == 0));
        chk("b_ready", 64'(b_if.req_ready), 64'(rd_win == 1 || wr_win == 1));
        chk("mem_ren", 64'(mem_ren), 64'(rd_win >= 0));
        chk("mem_raddr", 64'(mem_raddr), 64'(e_raddr));
        chk("mem_wen", 64'(mem_wen), 64'(wr_win >= 0));
        chk("mem_waddr", 64'(mem_waddr), 64'(e_waddr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        chk("a_rsp_valid", 64'(a_if.rsp_valid), 64'(rst_n && m_own_v && m_own == 0));
        chk("b_rsp_valid", 64'(b_if.rsp_valid), 64'(rst_n && m_own_v && m_own == 1));
        chk("a_rsp_rdata", 64'(a_if.rsp_rdata), 64'(e_ra));
        chk("b_rsp_rdata", 64'(b_if.rsp_rdata), 64'(e_rb));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

        // Advance the model to the state after the coming posedge.
        if (!rst_n) begin
            m_last_rd = 1;
            m_last_wr = 1;
            m_cnt = 0;
            m_own_v = 1'b0;
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
        end else begin
            if (n_rd == 2) m_last_rd = rd_win;
            if (n_wr == 2) m_last_wr = wr_win;
            if (n_rd == 2 || n_wr == 2) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_own_v = (rd_win >= 0);
            m_own = rd_win;
            if (rd_win >= 0)
                m_data = (wr_win >= 0 && e_waddr == e_raddr) ? e_wdata : m_mem[e_raddr[3:0]];
            if (wr_win >= 0) m_mem[e_waddr[3:0]] = e_wdata;
        end
    end

    task automatic drive(input bit av, input bit awe, input int aad, input logic [DW-1:0] ad,
                         input bit bv, input bit bwe, input int bad, input logic [DW-1:0] bd);
        a_if.req_valid = av;  a_if.req_we = awe; a_if.req_addr = AW'(aad); a_if.req_wdata = ad;
        b_if.req_valid = bv;  b_if.req_we = bwe; b_if.req_addr = AW'(bad); b_if.req_wdata = bd;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mixed tail vectors: {a_valid, a_we, a_addr, b_valid, b_we, b_addr}
    int tv_a [6][3] = '{'{1,0,5}, '{1,1,3}, '{0,0,0}, '{1,0,3}, '{1,1,4}, '{1,0,4}};
    int tv_b [6][3] = '{'{1,1,5}, '{1,1,6}, '{1,0,6}, '{1,0,5}, '{1,0,4}, '{1,1,2}};

    initial begin
        drive(1, 0, 3, '0, 1, 1, 4, 32'h55);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(a_if.req_ready), 64'd0);
        chk("rst_b_ready", 64'(b_if.req_ready), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_mem_ren", 64'(mem_ren), 64'd0);
        chk("rst_rsp_valid", 64'(a_if.rsp_valid | b_if.rsp_valid), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // A writes, B reads it back.
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0);
        @(negedge clk);
        chk("wr_a_ready", 64'(a_if.req_ready), 64'd1);
        chk("wr_waddr", 64'(mem_waddr), 64'd5);
        step();
        drive(0, 0, 0, '0, 1, 0, 5, '0);
        @(negedge clk);
        chk("rd_b_ready", 64'(b_if.req_ready), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("rd_b_rsp_valid", 64'(b_if.rsp_valid), 64'd1);
        chk("rd_b_rsp_rdata", 64'(b_if.rsp_rdata), 64'hDEADBEEF);
        chk("rd_a_rsp_valid", 64'(a_if.rsp_valid), 64'd0);
        step();

        // Preload, then four read conflicts alternate A,B,A,B.
        drive(1, 1, 1, 32'h1111, 0, 0, 0, '0);
        step();
        drive(1, 1, 2, 32'h2222, 0, 0, 0, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, '0, 1, 0, 2, '0);
            @(negedge clk);
            chk("rr_a_ready", 64'(a_if.req_ready), 64'(i % 2 == 0));
            if (i == 2) chk("rr_b_rsp", 64'(b_if.rsp_rdata), 64'h2222);
            step();
        end
        idle();
        @(negedge clk);
        chk("rr_cnt", 64'(conflict_cnt), 64'd4);
        step();

        // Same-address read and write in one cycle; no conflict.
        drive(1, 0, 7, '0, 1, 1, 7, 32'h1234);
        @(negedge clk);
        chk("fwd_both_ready", 64'(a_if.req_ready & b_if.req_ready), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("fwd_a_rdata", 64'(a_if.rsp_rdata), 64'h1234);
        chk("fwd_cnt", 64'(conflict_cnt), 64'd4);
        step();

        // Write conflicts leave the read pointer alone.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8, DW'(i), 1, 1, 9, DW'(i + 16));
            step();
        end
        drive(1, 0, 1, '0, 1, 0, 2, '0);
        @(negedge clk);
        chk("ptr_a_ready", 64'(a_if.req_ready), 64'd1);
        chk("ptr_b_ready", 64'(b_if.req_ready), 64'd0);
        chk("ptr_cnt", 64'(conflict_cnt), 64'd7);
        step();

        // 11 more conflicts: 19 total saturates a 4-bit counter at 15.
        for (int i = 0; i < 11; i++) begin
            drive(1, 0, 8, '0, 1, 0, 9, '0);
            step();
        end
        idle();
        @(negedge clk);
        chk("sat_cnt", 64'(conflict_cnt), 64'd15);
        step();

        // Reset right after a read grant drops the response.
        drive(1, 0, 1, '0, 0, 0, 0, '0);
        step();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstrd_a_valid", 64'(a_if.rsp_valid), 64'd0);
        chk("rstrd_a_rdata", 64'(a_if.rsp_rdata), 64'd0);
        step();
        @(negedge clk);
        chk("rstrd_cnt", 64'(conflict_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            drive(tv_a[i][0] != 0, tv_a[i][1] != 0, tv_a[i][2], DW'(32'hA000 + i),
                  tv_b[i][0] != 0, tv_b[i][1] != 0, tv_b[i][2], DW'(32'hB000 + i));
            step();
        end
        idle();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares one dual-port SRAM (one write port, one read port, 1-cycle registered read) between the CPU data path (requester A) and the memory loader/debug path (requester B). Reads and writes are arbitrated independently, each with its own 1-bit round-robin pointer, so one read and one write can be granted in the same cycle. The block routes each read response back to its issuer and counts arbitration conflicts. It sits between the core/loader and the data SRAM instance.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, word address width
- CNT_WIDTH, 16, conflict counter width

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_req_valid / b_req_valid  in  1  request present
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_WIDTH  word address
- a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data
- a_req_ready / b_req_ready  out  1  request accepted this cycle
- a_rsp_valid / b_rsp_valid  out  1  read data valid
- a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data
- mem_wen  out  1  SRAM write enable
- mem_waddr  out  ADDR_WIDTH  SRAM write address
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_ren  out  1  SRAM read enable
- mem_raddr  out  ADDR_WIDTH  SRAM read address
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_ren
- conflict_cnt  out  CNT_WIDTH  saturating count of same-port contentions

## Operation
- A request transfers when req_valid && req_ready in the same cycle; requester holds addr/we/wdata stable until accepted.
- Per cycle: read candidates = {X : X_req_valid && !X_req_we}; write candidates = {X : X_req_valid && X_req_we}.
- One candidate on a port: granted immediately.
- Two candidates on a port: grant the requester NOT recorded in that port's last-grant pointer; update pointer to the winner; loser's ready = 0; conflict_cnt += 1 (saturates at all-ones, no wrap).
- Read and write pointers are independent; a write grant never moves the read pointer and vice versa.
- Pointer reset value: last = B on both ports (A wins first conflict).
- Granted write: mem_wen = 1, mem_waddr/mem_wdata from winner; otherwise mem_wen = 0, addr/data = 0.
- Granted read: mem_ren = 1, mem_raddr from winner; registered rd_owner (valid + id) captured.
- Cycle after read grant: owner's rsp_valid = 1, owner's rsp_rdata = mem_rdata; other requester's rsp_rdata = 0.
- Same-address read and write granted in one cycle: read returns new wdata (SRAM forwarding); arbiter passes it through unchanged.
- Back-to-back reads allowed every cycle; no outstanding-limit beyond the 1-cycle pipeline.

## Timing
- Grant/ready and mem_* outputs: combinational from current req_* and pointers (ready may depend on valid; valid must not depend on ready).
- Read latency: request accepted cycle N -> rsp_valid cycle N+1. Write: committed at the clock edge ending cycle N.
- Pointers, rd_owner, conflict_cnt update on posedge clk.
- Reset (rst_n = 0 at posedge): pointers = B, rd_owner cleared, conflict_cnt = 0, a/b_rsp_valid = 0, rsp_rdata = 0. While rst_n = 0: a/b_req_ready = 0, mem_wen = 0, mem_ren = 0, all mem addr/data = 0.
- Reset asserted the cycle after a read grant: rsp_valid for that read is dropped (0); no response is delivered after reset.

## Test plan
- Reset: hold rst_n = 0 with both valid -> readies 0, mem_wen/mem_ren 0, rsp_valid 0, conflict_cnt 0.
- A writes 0xDEADBEEF to addr 5, next cycle B reads 5 -> B ready same cycle, b_rsp_valid cycle+1 with 0xDEADBEEF, a_rsp_valid stays 0.
- A and B both read (addr 1, addr 2) for 4 cycles -> grants A,B,A,B; responses alternate; conflict_cnt = 4.
- A reads addr 7 while B writes 0x1234 to addr 7 same cycle -> both ready; a_rsp_rdata = 0x1234 next cycle; conflict_cnt unchanged.
- Both write continuously while both read pointers untouched; then both read -> first read conflict granted to A (read pointer still reset value).
- Drive 2^CNT_WIDTH+3 conflicts (CNT_WIDTH = 4 build) -> conflict_cnt saturates at 15; reset mid read returns rsp_valid = 0 next cycle.
